// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the shared memory port arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_sel;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              stall;

  logic              mem_ce;
  logic              mem_we;
  logic [3:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_sel, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, stall,
           mem_ce, mem_we, mem_sel, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_sel, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, stall,
           mem_ce, mem_we, mem_sel, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access.
// Data has priority; fetch wins a contested grant after two contested data wins.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no transaction, arbitrate pending requests
  // BUSY  | memory access in progress, mem_ce held for LAT cycles
  // RESP  | one-cycle ack to the owner with registered read data
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT   = 4'(LAT - 1);
  localparam logic [1:0] STREAK_MAX = 2'd2;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [1:0]        streak;
  logic              own_dm;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              grant_dm;
  logic              grant_if;
  logic              busy;

  // A contested data request loses only once the streak limit is reached.
  always_comb begin
    grant_dm  = 1'b0;
    grant_if  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        grant_dm = bus.dm_req & ~(bus.if_req & (streak == STREAK_MAX));
        grant_if = bus.if_req & ~grant_dm;
        if (grant_dm | grant_if) state_nxt = BUSY;
      end
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      streak  <= 2'd0;
      own_dm  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dm | grant_if) begin
            cnt     <= CNT_INIT;
            own_dm  <= grant_dm;
            addr_q  <= grant_dm ? bus.dm_addr : bus.if_addr;
            we_q    <= grant_dm & bus.dm_we;
            sel_q   <= grant_dm ? bus.dm_sel : 4'hF;
            wdata_q <= grant_dm ? bus.dm_wdata : '0;
          end
          if (grant_if)
            streak <= 2'd0;
          else if (grant_dm && bus.if_req && streak != STREAK_MAX)
            streak <= streak + 2'd1;
        end
        BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             rdata_q <= we_q ? '0 : bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == BUSY);

  assign bus.mem_ce    = busy;
  assign bus.mem_we    = busy & we_q;
  assign bus.mem_sel   = busy ? sel_q : 4'h0;
  assign bus.mem_addr  = busy ? addr_q : '0;
  assign bus.mem_wdata = busy ? wdata_q : '0;

  assign bus.if_ack   = (state == RESP) & ~own_dm;
  assign bus.dm_ack   = (state == RESP) & own_dm;
  assign bus.if_rdata = rdata_q;
  assign bus.dm_rdata = rdata_q;

  assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.dm_req & ~bus.dm_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LAT=2 instance for most scenarios,
// LAT=1 instance for back-to-back fetches.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(2)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory model: one fixed word at 0x100, otherwise {addr[15:0], 16'hBEEF}
  assign bus.mem_rdata  = (bus.mem_addr == 32'h100) ? 32'h3C011234
                                                    : {bus.mem_addr[15:0], 16'hBEEF};
  assign bus1.mem_rdata = {bus1.mem_addr[15:0], 16'hBEEF};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] acks;
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({bus.mem_ce, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, bus.if_ack,
         bus.dm_ack, bus.stall, bus.if_rdata, bus.dm_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ce=%b addr=%h ack=%b%b stall=%b rdata=%h, required all 0",
               bus.mem_ce, bus.mem_addr, bus.if_ack, bus.dm_ack, bus.stall, bus.if_rdata);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    tick();
    n_cmp++;
    if ({bus.mem_ce, bus.mem_addr} !== {1'b1, 32'h40}) begin
      n_err++;
      $display("FAIL reset_pre_busy: got ce=%b addr=%h, required ce=1 addr=00000040",
               bus.mem_ce, bus.mem_addr);
    end
    rst = 1'b1;
    bus.if_req = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_ce, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, bus.if_ack,
         bus.dm_ack, bus.stall, bus.if_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_busy: got ce=%b sel=%h addr=%h ack=%b%b stall=%b, required all 0",
               bus.mem_ce, bus.mem_sel, bus.mem_addr, bus.if_ack, bus.dm_ack, bus.stall);
    end
    tick();
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.if_ack || bus.dm_ack) acks++;
    end
    n_cmp++;
    if (acks !== 32'd0) begin
      n_err++;
      $display("FAIL reset_no_ack: got %0d acks after abort, required 0", acks);
    end
  endtask

  task automatic test_single_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_stall_req: got %b, required 1", bus.stall);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({bus.mem_ce, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.if_ack, bus.stall} !==
          {1'b1, 1'b0, 4'hF, 32'h100, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL fetch_busy%0d: got ce=%b we=%b sel=%h addr=%h ack=%b stall=%b, required 1 0 f 00000100 0 1",
                 i, bus.mem_ce, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.if_ack, bus.stall);
      end
    end
    tick();
    n_cmp++;
    if ({bus.if_ack, bus.dm_ack, bus.if_rdata, bus.mem_ce, bus.stall} !==
        {1'b1, 1'b0, 32'h3C011234, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL fetch_ack: got ack=%b%b rdata=%h ce=%b stall=%b, required 1 0 3c011234 0 0",
               bus.if_ack, bus.dm_ack, bus.if_rdata, bus.mem_ce, bus.stall);
    end
    tick();
    bus.if_req = 1'b0;
    #1;
    n_cmp++;
    if ({bus.if_ack, bus.mem_ce} !== 2'b00) begin
      n_err++;
      $display("FAIL fetch_after: got ack=%b ce=%b, required 0 0", bus.if_ack, bus.mem_ce);
    end
  endtask

  task automatic test_store();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_sel   = 4'b0011;
    bus.dm_addr  = 32'h2004;
    bus.dm_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({bus.mem_ce, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata} !==
          {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hDEADBEEF}) begin
        n_err++;
        $display("FAIL store_busy%0d: got ce=%b we=%b sel=%h addr=%h wdata=%h, required 1 1 3 00002004 deadbeef",
                 i, bus.mem_ce, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata);
      end
    end
    tick();
    n_cmp++;
    if ({bus.dm_ack, bus.if_ack, bus.dm_rdata, bus.mem_we} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL store_ack: got ack=%b%b rdata=%h we=%b, required 1 0 00000000 0",
               bus.dm_ack, bus.if_ack, bus.dm_rdata, bus.mem_we);
    end
    tick();
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
  endtask

  task automatic test_simultaneous();
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h200;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_sel   = 4'hF;
    bus.dm_addr  = 32'h300;
    bus.dm_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({bus.mem_ce, bus.mem_addr} !== {1'b1, 32'h300}) begin
        n_err++;
        $display("FAIL simul_data_busy%0d: got ce=%b addr=%h, required 1 00000300",
                 i, bus.mem_ce, bus.mem_addr);
      end
    end
    tick();
    n_cmp++;
    if ({bus.dm_ack, bus.if_ack, bus.dm_rdata} !== {1'b1, 1'b0, 32'h0300BEEF}) begin
      n_err++;
      $display("FAIL simul_data_ack: got ack=%b%b rdata=%h, required 1 0 0300beef",
               bus.dm_ack, bus.if_ack, bus.dm_rdata);
    end
    tick();
    bus.dm_req = 1'b0;
    n_cmp++;
    if (bus.mem_ce !== 1'b0) begin
      n_err++;
      $display("FAIL simul_gap: got ce=%b, required 0", bus.mem_ce);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({bus.mem_ce, bus.mem_addr, bus.mem_sel} !== {1'b1, 32'h200, 4'hF}) begin
        n_err++;
        $display("FAIL simul_fetch_busy%0d: got ce=%b addr=%h sel=%h, required 1 00000200 f",
                 i, bus.mem_ce, bus.mem_addr, bus.mem_sel);
      end
    end
    tick();
    n_cmp++;
    if ({bus.if_ack, bus.dm_ack, bus.if_rdata} !== {1'b1, 1'b0, 32'h0200BEEF}) begin
      n_err++;
      $display("FAIL simul_fetch_ack: got ack=%b%b rdata=%h, required 1 0 0200beef",
               bus.if_ack, bus.dm_ack, bus.if_rdata);
    end
    tick();
    bus.if_req = 1'b0;
  endtask

  task automatic test_starvation();
    string       exp_order = "DDIDDI";
    logic [7:0]  got_c;
    logic [7:0]  exp_c;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    int          n_ack = 0;
    int          last = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h400;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_sel  = 4'hF;
    bus.dm_addr = 32'h500;
    for (int k = 0; k < 60 && n_ack < 6; k++) begin
      tick();
      if (bus.if_ack && bus.dm_ack) begin
        n_cmp++;
        n_err++;
        $display("FAIL starve_both_ack: got if_ack=1 dm_ack=1, required one of them");
      end else if (bus.if_ack || bus.dm_ack) begin
        got_c  = bus.dm_ack ? "D" : "I";
        got_rd = bus.dm_ack ? bus.dm_rdata : bus.if_rdata;
        exp_c  = exp_order[n_ack];
        exp_rd = (exp_c == "D") ? 32'h0500BEEF : 32'h0400BEEF;
        n_cmp++;
        if ({got_c, got_rd} !== {exp_c, exp_rd}) begin
          n_err++;
          $display("FAIL starve_grant%0d: got %c rdata=%h, required %c rdata=%h",
                   n_ack, got_c, got_rd, exp_c, exp_rd);
        end
        if (n_ack > 0) begin
          n_cmp++;
          if (cyc - last !== 4) begin
            n_err++;
            $display("FAIL starve_spacing%0d: got %0d cycles, required 4", n_ack, cyc - last);
          end
        end
        last = cyc;
        n_ack++;
      end
    end
    n_cmp++;
    if (n_ack !== 6) begin
      n_err++;
      $display("FAIL starve_timeout: got %0d acks, required 6", n_ack);
    end
    tick();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] seen_addr [3];
    int          n_seen = 0;
    int          ack_cyc [3];
    logic        got;
    for (int j = 0; j < 3; j++) begin
      bus1.if_req  = 1'b1;
      bus1.if_addr = 32'(j * 4);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        tick();
        if (bus1.mem_ce && n_seen < 3) begin
          seen_addr[n_seen] = bus1.mem_addr;
          n_seen++;
        end
        if (bus1.if_ack) begin
          got        = 1'b1;
          ack_cyc[j] = cyc;
          n_cmp++;
          if (bus1.if_rdata !== {16'(j * 4), 16'hBEEF}) begin
            n_err++;
            $display("FAIL b2b_rdata%0d: got %h, required %h",
                     j, bus1.if_rdata, {16'(j * 4), 16'hBEEF});
          end
        end
      end
      if (!got) begin
        n_cmp++;
        n_err++;
        $display("FAIL b2b_timeout%0d: got no if_ack, required one within 10 cycles", j);
        ack_cyc[j] = 0;
      end
      tick();
    end
    bus1.if_req = 1'b0;
    n_cmp++;
    if (n_seen !== 3) begin
      n_err++;
      $display("FAIL b2b_ce_count: got %0d ce cycles, required 3", n_seen);
    end else begin
      n_cmp++;
      if ({seen_addr[0], seen_addr[1], seen_addr[2]} !== {32'h0, 32'h4, 32'h8}) begin
        n_err++;
        $display("FAIL b2b_addr_seq: got %h %h %h, required 0 4 8",
                 seen_addr[0], seen_addr[1], seen_addr[2]);
      end
    end
    for (int j = 1; j < 3; j++) begin
      n_cmp++;
      if (ack_cyc[j] - ack_cyc[j-1] !== 3) begin
        n_err++;
        $display("FAIL b2b_spacing%0d: got %0d cycles, required 3", j, ack_cyc[j] - ack_cyc[j-1]);
      end
    end
  endtask

  initial begin
    bus.if_req = 1'b0;   bus.if_addr = '0;
    bus.dm_req = 1'b0;   bus.dm_we = 1'b0;   bus.dm_sel = 4'h0;
    bus.dm_addr = '0;    bus.dm_wdata = '0;
    bus1.if_req = 1'b0;  bus1.if_addr = '0;
    bus1.dm_req = 1'b0;  bus1.dm_we = 1'b0;  bus1.dm_sel = 4'h0;
    bus1.dm_addr = '0;   bus1.dm_wdata = '0;
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run, required finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single fixed-latency memory port between the CPU's instruction-fetch requester and its data (load/store) requester. Sits in the SOPC between the ToruMIPS core and one unified instruction/data memory, replacing a dedicated instruction-ROM port. Data accesses have priority, with an anti-starvation rule for fetch. Each transaction completes with a one-cycle acknowledge pulse carrying read data.

## Interface
- `ADDR_W`, default 32: address width of both requesters and the memory.
- `DATA_W`, default 32: data width.
- `LAT`, default 2: number of cycles `mem_ce` is held per access. Legal range is 1..15.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request. Held high until `if_ack`.
- `if_addr` in ADDR_W: fetch address. Stable while `if_req` is high.
- `if_ack` out 1: one-cycle completion pulse for fetch.
- `if_rdata` out DATA_W: fetch data. Valid only while `if_ack` is high.
- `dm_req` in 1: data request. Held high until `dm_ack`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_sel` in 4: byte enables.
- `dm_addr` in ADDR_W: data address.
- `dm_wdata` in DATA_W: store data.
- `dm_ack` out 1: one-cycle completion pulse for data.
- `dm_rdata` out DATA_W: load data. Valid while `dm_ack` is high. 0 for stores.
- `stall` out 1: a request is pending and not yet acknowledged; goes to the pipeline stall controller.
- `mem_ce` out 1: memory chip enable.
- `mem_we` out 1: memory write enable.
- `mem_sel` out 4: memory byte enables.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data. Valid in the last `mem_ce` cycle.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - With no request pending, stay in IDLE.
  - With a request pending, pick a winner:
    - Only one requester asserting: it wins.
    - Both asserting: data wins, unless `streak` == 2, in which case fetch wins.
  - Latch into the transaction registers:
    - owner, address;
    - `we`/`sel`/`wdata` (data owner), or `we`=0, `sel`=4'hF, `wdata`=0 (fetch owner).
  - Load `cnt` = LAT-1 and go to BUSY.
- **streak** (2 bits)
  - Increments, saturating at 2, on a data grant made while `if_req` was high.
  - Clears on any fetch grant.
  - Unchanged on a data grant made with `if_req` low.
- **BUSY**
  - `mem_ce`=1; `mem_we`/`mem_sel`/`mem_addr`/`mem_wdata` are driven from the latched registers.
  - When `cnt` != 0: decrement `cnt` and stay in BUSY.
  - When `cnt` == 0, on that edge:
    - read: register `mem_rdata` into `rdata`;
    - write: register 0 into `rdata`;
    - go to RESP.
- **RESP**
  - The owner's ack = 1. The other requester's ack = 0.
  - Both `if_rdata` and `dm_rdata` are driven from the single `rdata` register.
  - Always go to IDLE on the next edge. There is no direct RESP→BUSY transition.
- Requester protocol: a requester deasserts `req` (or presents a new request) in the cycle after it sees ack. Changing `addr`/`wdata` while a request is unacknowledged is a protocol violation; the latched values are used.
- `stall` = (`if_req` & ~`if_ack`) | (`dm_req` & ~`dm_ack`). Combinational.
- Outside BUSY, `mem_ce`, `mem_we`, `mem_sel`, `mem_addr` and `mem_wdata` are all 0.

## Timing
- Reset (async, immediate):
  - state = IDLE, `cnt` = 0, `streak` = 0, `rdata` = 0, latched registers = 0.
  - All outputs are 0.
  - An in-flight transaction is aborted with no ack. A `mem_we` pulse cut short by reset is tolerated by the memory.
- Latency: request first seen in IDLE at edge N → `mem_ce` high for cycles N+1..N+LAT → ack high during cycle N+LAT+1.
- Minimum spacing between acks is LAT+2 cycles.
- Simultaneous request arrival is resolved only in IDLE. A request arriving during BUSY/RESP waits.
- `rdata` holds its value after RESP until the next completion. Consumers use it only while ack is high.

## Test plan
- **Reset:** drive `rst`=1 mid-BUSY with LAT=2.
  - All outputs drop to 0 in the same cycle.
  - After release, no `if_ack`/`dm_ack` occurs for the aborted transaction.
- **Single fetch:** `if_req`=1, `if_addr`=0x100, memory returns 0x3C011234, LAT=2.
  - `mem_ce` high for 2 cycles with `mem_addr`=0x100 and `mem_sel`=4'hF.
  - `if_ack` pulses one cycle later with `if_rdata`=0x3C011234.
  - `stall` is high from the request cycle through the cycle before `if_ack`.
- **Store:** `dm_req`=1, `dm_we`=1, `dm_sel`=4'b0011, `dm_addr`=0x2004, `dm_wdata`=0xDEADBEEF.
  - `mem_we`=1 for LAT cycles with these exact values.
  - `dm_ack` pulses with `dm_rdata`=0.
- **Simultaneous arrival:** `if_req` and `dm_req` rise in the same cycle.
  - Data is served first.
  - Fetch `mem_ce` starts exactly LAT+2 cycles after the data `mem_ce` started.
- **Anti-starvation:** `if_req` held high while `dm_req` is re-asserted immediately after each `dm_ack`.
  - Grant order is D, D, I, D, D, I.
  - `streak` never exceeds 2.
- **LAT=1 back-to-back fetches:** `if_req` re-asserted the cycle after each ack with addresses 0, 4, 8.
  - Acks arrive every 3 cycles.
  - `mem_addr` sequence is 0, 4, 8.
